unstacker_param: RTL
====================

# unstacker_param

Parametrised AXI-Stream width-down converter: accepts wide phrases (`IN_W` bits) and emits them as a stream of narrow words (`OUT_W` bits), least-significant word first. It sits between the DRAM read path and the pixel pipeline. It generalises the fixed 128→8 unstacker and adds the following:

- Sustained zero-bubble throughput.
- A start-of-packet flag.
- An optional partial final phrase.

## Interface
- `IN_W`, default 128: input phrase width; must be a multiple of `OUT_W`.
- `OUT_W`, default 8: output word width.
- `N` (localparam) = `IN_W/OUT_W`: words per phrase, ≥2.
- `CW` (localparam) = `$clog2(N+1)`: count width.

Ports:
- `clk_in`  in  1: single clock.
- `rst_n_in`  in  1: reset, asynchronous, active-low.
- `chunk_tvalid`  in  1: input phrase valid.
- `chunk_tready`  out  1: input phrase accepted when high with `chunk_tvalid`.
- `chunk_tdata`  in  `IN_W`: phrase; word 0 = bits `[OUT_W-1:0]`.
- `chunk_tlast`  in  1: phrase ends a packet.
- `chunk_tcount`  in  `CW`: valid words in a `tlast` phrase (present only with `UNSTACKER_PARTIAL_EN`).
- `pixel_tvalid`  out  1: output word valid.
- `pixel_tready`  in  1: downstream ready.
- `pixel_tdata`  out  `OUT_W`: output word.
- `pixel_tlast`  out  1: last word of a packet.
- `pixel_tuser`  out  1: first word of a packet.

## Operation
- **State**: phrase register, word offset (`$clog2(N)` bits), last-index register, `tlast`/sop hold bits, `full` flag. Two states: EMPTY (`full=0`) and HOLD (`full=1`).
- **Reset**: async-low clears `full`, offset, and phrase; sets sop.
  - During and after reset: `pixel_tvalid=0`, `pixel_tdata=0`, `pixel_tlast=0`, `pixel_tuser=0`.
  - `chunk_tready=0` while reset is asserted and 1 afterwards (EMPTY).
- **Ready rule**: `chunk_tready = !full || (offset==last_idx && pixel_tready)`. This is combinational from `pixel_tready`.
- **EMPTY + accept**: load the phrase, `offset=0`, and latch `tlast`. Go to HOLD.
- **HOLD, output handshake, `offset<last_idx`**: `offset+1`; shift the phrase right by `OUT_W`.
- **HOLD, handshake at `offset==last_idx`**:
  - If a new phrase is simultaneously accepted: reload it with `offset=0` and stay in HOLD. There is no bubble.
  - Otherwise: go to EMPTY.
- **Word outputs**:
  - `pixel_tdata` = low `OUT_W` bits of the phrase register.
  - `pixel_tvalid = full`.
  - `pixel_tlast = full && tlast_hold && offset==last_idx`.
- **sop**: `pixel_tuser` is high on the first word emitted after reset or after a `pixel_tlast` handshake. It is high only on that one word.
- **last_idx**: `N-1`, except in the partial case defined under Configuration.
- **Stall**: while `pixel_tvalid && !pixel_tready`, all `pixel_*` outputs are held stable.
- **Input mid-flight**: no input is accepted before the last word of the current phrase.

## Timing
- Latency: a phrase accepted at edge k has word 0 valid from edge k+1.
- Throughput: 1 word/cycle sustained when `chunk_tvalid` is held high and `pixel_tready=1`. There is no gap between phrases.
- Phrase gap: if no phrase is valid at the last word, `pixel_tvalid` drops at the next edge. The next phrase is then accepted in EMPTY and appears one cycle later.
- Reset mid-packet: the packet is discarded immediately. No `tlast` is produced for it. The first post-reset word carries `tuser=1`.

## Configuration
- `UNSTACKER_PARTIAL_EN` defined:
  - The `chunk_tcount` port exists.
  - On a `tlast` phrase, `last_idx = chunk_tcount-1`.
  - A `chunk_tcount` of 0 or >N is treated as N.
  - On non-`tlast` phrases, the count is ignored.
- Not defined:
  - The port is absent.
  - `last_idx` is always `N-1`, and every phrase emits N words.

## Structure
- Package `unstacker_pkg` holds:
  - Default `IN_W`/`OUT_W` localparams.
  - Function `clamp_last_idx(count, n)`, shared with the future stacker.
- No sub-module; single flat module.
- Add an elaboration assertion that `IN_W % OUT_W == 0` and `N >= 2`.

## Test plan
All scenarios use `IN_W=32` and `OUT_W=8`.
- **Reset, idle**: deassert `rst_n_in`, keep `chunk_tvalid=0` → `pixel_tvalid=0` and `chunk_tready=1`.
- **Single packet**: phrase `0x44332211` with `tlast=1` → words `11,22,33,44`; `tuser` only on `11`; `tlast` only on `44`.
- **Back-to-back, `pixel_tready=1`**:
  - Input: phrases `0xA3A2A1A0` then `0xB3B2B1B0`, the second with `tlast`.
  - Expected: 8 consecutive valid cycles with no bubble.
  - Expected: `chunk_tready=1` on the 4th word cycle.
- **Backpressure**: `pixel_tready` toggles 1,0,0,1 → `pixel_tdata` is stable during the stalls, and no word is dropped or duplicated.
- **Partial last** (`UNSTACKER_PARTIAL_EN`): phrase `0x00CCBBAA` with `tlast=1` and `tcount=3` → words `AA,BB,CC`; `tlast` on `CC`. A following phrase gets `tuser=1`.
- **Reset mid-phrase**: assert `rst_n_in` after word 1 → `pixel_tvalid` goes to 0 asynchronously. The next packet's first word has `tuser=1`.

Source files
------------

// File: rtl/unstacker_pkg.sv
// rtl/unstacker_pkg.sv - shared defaults, state type and count clamp for the unstacker family
package unstacker_pkg;

  localparam int IN_W_DEF  = 128;
  localparam int OUT_W_DEF = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Map a tlast word count onto the index of the final word; 0 or
  // anything above n means a full phrase.
  function automatic int clamp_last_idx(input int count, input int n);
    if (count <= 0 || count > n) return n - 1;
    return count - 1;
  endfunction

endpackage

// File: rtl/unstacker_param_if.sv
// rtl/unstacker_param_if.sv - phrase-in / word-out stream bundle (chunk_tcount only with UNSTACKER_PARTIAL_EN)
interface unstacker_param_if
  import unstacker_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);
`ifdef UNSTACKER_PARTIAL_EN
  localparam int N  = IN_W / OUT_W;
  localparam int CW = $clog2(N + 1);
`endif

  logic             chunk_tvalid;
  logic             chunk_tready;
  logic [IN_W-1:0]  chunk_tdata;
  logic             chunk_tlast;
`ifdef UNSTACKER_PARTIAL_EN
  logic [CW-1:0]    chunk_tcount;
`endif
  logic             pixel_tvalid;
  logic             pixel_tready;
  logic [OUT_W-1:0] pixel_tdata;
  logic             pixel_tlast;
  logic             pixel_tuser;

  // Converter side: consumes phrases, produces words.
  modport slave (
    input  chunk_tvalid, chunk_tdata, chunk_tlast,
`ifdef UNSTACKER_PARTIAL_EN
    input  chunk_tcount,
`endif
    output chunk_tready,
    output pixel_tvalid, pixel_tdata, pixel_tlast, pixel_tuser,
    input  pixel_tready
  );

  // Surrounding logic side: produces phrases, consumes words.
  modport master (
    output chunk_tvalid, chunk_tdata, chunk_tlast,
`ifdef UNSTACKER_PARTIAL_EN
    output chunk_tcount,
`endif
    input  chunk_tready,
    input  pixel_tvalid, pixel_tdata, pixel_tlast, pixel_tuser,
    output pixel_tready
  );

endinterface

// File: rtl/unstacker_param.sv
// rtl/unstacker_param.sv - IN_W to OUT_W stream width-down converter, LS word first (partial last phrase with UNSTACKER_PARTIAL_EN)
module unstacker_param
  import unstacker_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  unstacker_param_if.slave bus
);

  localparam int N  = IN_W / OUT_W;
  localparam int OW = $clog2(N);

  if ((IN_W % OUT_W) != 0 || N < 2) begin : g_bad_cfg
    $error("unstacker_param: IN_W must be a multiple of OUT_W with at least two words");
  end

  state_t          r_state, w_state_nxt;
  logic [IN_W-1:0] r_phrase, w_phrase_nxt;
  logic [OW-1:0]   r_offset, w_offset_nxt;
  logic [OW-1:0]   r_last_idx, w_last_idx_nxt;
  logic [OW-1:0]   w_load_idx;
  logic            r_tlast, w_tlast_nxt;
  logic            r_sop, w_sop_nxt;
  logic            w_full, w_at_last, w_out_hs, w_in_hs, w_ready, w_plast;

  assign w_full    = (r_state == ST_HOLD);
  assign w_at_last = (r_offset == r_last_idx);
  assign w_out_hs  = w_full && bus.pixel_tready;
  // Ready is held low during reset; otherwise a reload may overlap the final word.
  assign w_ready   = rst_n_in && (!w_full || (w_at_last && bus.pixel_tready));
  assign w_in_hs   = bus.chunk_tvalid && w_ready;
  assign w_plast   = w_full && r_tlast && w_at_last;

`ifdef UNSTACKER_PARTIAL_EN
  assign w_load_idx = bus.chunk_tlast ? OW'(clamp_last_idx(int'(bus.chunk_tcount), N))
                                      : OW'(N - 1);
`else
  assign w_load_idx = OW'(N - 1);
`endif

  assign bus.chunk_tready = w_ready;
  assign bus.pixel_tvalid = w_full;
  assign bus.pixel_tdata  = r_phrase[OUT_W-1:0];
  assign bus.pixel_tlast  = w_plast;
  assign bus.pixel_tuser  = w_full && r_sop;

  // Next-state: load on accept, otherwise step through words on each output handshake.
  always_comb begin
    w_state_nxt    = r_state;
    w_phrase_nxt   = r_phrase;
    w_offset_nxt   = r_offset;
    w_last_idx_nxt = r_last_idx;
    w_tlast_nxt    = r_tlast;
    w_sop_nxt      = r_sop;
    if (w_out_hs) begin
      w_sop_nxt = w_plast;
    end
    if (w_in_hs) begin
      w_state_nxt    = ST_HOLD;
      w_phrase_nxt   = bus.chunk_tdata;
      w_offset_nxt   = '0;
      w_last_idx_nxt = w_load_idx;
      w_tlast_nxt    = bus.chunk_tlast;
    end else if (w_out_hs) begin
      if (!w_at_last) begin
        w_offset_nxt = r_offset + OW'(1);
        w_phrase_nxt = r_phrase >> OUT_W;
      end else begin
        w_state_nxt = ST_EMPTY;
      end
    end
  end

  // State register; reset drops any in-flight phrase and re-arms start-of-packet.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= ST_EMPTY;
      r_phrase   <= '0;
      r_offset   <= '0;
      r_last_idx <= OW'(N - 1);
      r_tlast    <= 1'b0;
      r_sop      <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_phrase   <= w_phrase_nxt;
      r_offset   <= w_offset_nxt;
      r_last_idx <= w_last_idx_nxt;
      r_tlast    <= w_tlast_nxt;
      r_sop      <= w_sop_nxt;
    end
  end

endmodule
